sort_result_checker: RTL



---
 rtl/sort_result_checker_if.sv | 26 ++
 rtl/sort_result_checker.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/sort_result_checker_if.sv
// Bus bundle between the sorter/consumer side and sort_result_checker.
// Carries the IRAM write stream, the done flag, the read port and the status outputs.
interface sort_result_checker_if;
  logic       IRAM_valid;
  logic [3:0] IRAM_A;
  logic [7:0] IRAM_D;
  logic       done;
  logic       RD_rd;
  logic [3:0] RD_A;
  logic [7:0] RD_Q;
  logic [4:0] wr_count;
  logic       check_done;
  logic       check_pass;
  logic [1:0] err_code;
  logic [3:0] err_addr;

  modport master (
    output IRAM_valid, IRAM_A, IRAM_D, done, RD_rd, RD_A,
    input  RD_Q, wr_count, check_done, check_pass, err_code, err_addr
  );

  modport slave (
    input  IRAM_valid, IRAM_A, IRAM_D, done, RD_rd, RD_A,
    output RD_Q, wr_count, check_done, check_pass, err_code, err_addr
  );
endinterface

// File: rtl/sort_result_checker.sv
// sort_result_checker: captures a 16x8 sorter result stream, then checks that
// every address was written and that contents are non-decreasing by address.
// Optional feature macro: SORT_CHK_CONFLICT_EN (flags conflicting rewrites).
module sort_result_checker (
  input  logic                 clk,
  input  logic                 reset,
  sort_result_checker_if.slave bus
);

  typedef enum logic [1:0] {CAP = 2'd0, SCAN = 2'd1, REPORT = 2'd2} state_t;

  state_t      r_state, w_state_nxt;
  logic [7:0]  r_mem [16];
  logic [15:0] r_mask;
  logic [4:0]  r_wr_count;
  logic [3:0]  r_idx, r_cidx;
  logic        r_cv, r_bad;
  logic [1:0]  r_err_code, w_err_code_nxt;
  logic [3:0]  r_err_addr, w_err_addr_nxt;
  logic [7:0]  r_rd_q;
  logic        w_wr;
  logic [3:0]  w_idx_p1;
  logic [3:0]  w_miss_addr;
  logic        w_conflict;
  logic [3:0]  w_conf_addr;

  assign w_wr     = (r_state == CAP) && bus.IRAM_valid;
  assign w_idx_p1 = r_idx + 4'd1;

`ifdef SORT_CHK_CONFLICT_EN
  logic       r_conflict;
  logic [3:0] r_conf_addr;
  logic       w_conf_now;

  assign w_conf_now = w_wr && r_mask[bus.IRAM_A] && (bus.IRAM_D != r_mem[bus.IRAM_A]);

  // Latch the lowest address that ever saw a conflicting rewrite during capture
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_conflict  <= 1'b0;
      r_conf_addr <= '0;
    end else if (w_conf_now && (!r_conflict || bus.IRAM_A < r_conf_addr)) begin
      r_conflict  <= 1'b1;
      r_conf_addr <= bus.IRAM_A;
    end
  end

  assign w_conflict  = r_conflict;
  assign w_conf_addr = r_conf_addr;
`else
  assign w_conflict  = 1'b0;
  assign w_conf_addr = '0;
`endif

  // Lowest unwritten address (descending walk so the lowest hit is assigned last)
  always_comb begin
    w_miss_addr = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (!r_mask[15 - i]) w_miss_addr = 4'(15 - i);
    end
  end

  // Capture storage; contents are not reset
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[bus.IRAM_A] <= bus.IRAM_D;
  end

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= CAP;
    else       r_state <= w_state_nxt;
  end

  // Next state and error latch values.
  // The first SCAN cycle performs the missing/conflict check while the compare
  // stage loads pair 0; each later cycle evaluates the pair loaded one cycle earlier.
  always_comb begin
    w_state_nxt    = r_state;
    w_err_code_nxt = r_err_code;
    w_err_addr_nxt = r_err_addr;
    unique case (r_state)
      CAP: begin
        if (bus.done) w_state_nxt = SCAN;
      end
      SCAN: begin
        if (!r_cv) begin
          if (w_conflict) begin
            w_state_nxt    = REPORT;
            w_err_code_nxt = 2'b11;
            w_err_addr_nxt = w_conf_addr;
          end else if (r_mask != '1) begin
            w_state_nxt    = REPORT;
            w_err_code_nxt = 2'b10;
            w_err_addr_nxt = w_miss_addr;
          end
        end else if (r_bad) begin
          w_state_nxt    = REPORT;
          w_err_code_nxt = 2'b01;
          w_err_addr_nxt = r_cidx;
        end else if (r_cidx == 4'd14) begin
          w_state_nxt    = REPORT;
          w_err_code_nxt = 2'b00;
        end
      end
      REPORT: w_state_nxt = REPORT;
      default: w_state_nxt = CAP;
    endcase
  end

  // Capture bookkeeping, scan compare stage, error latch and read port
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mask     <= '0;
      r_wr_count <= '0;
      r_idx      <= '0;
      r_cidx     <= '0;
      r_cv       <= 1'b0;
      r_bad      <= 1'b0;
      r_err_code <= '0;
      r_err_addr <= '0;
      r_rd_q     <= '0;
    end else begin
      if (bus.RD_rd) r_rd_q <= r_mem[bus.RD_A];
      if (w_wr) begin
        r_mask[bus.IRAM_A] <= 1'b1;
        if (!r_mask[bus.IRAM_A]) r_wr_count <= r_wr_count + 5'd1;
      end
      r_err_code <= w_err_code_nxt;
      r_err_addr <= w_err_addr_nxt;
      if (r_state == CAP) begin
        r_idx <= '0;
        r_cv  <= 1'b0;
      end else if (r_state == SCAN) begin
        r_bad  <= r_mem[r_idx] > r_mem[w_idx_p1];
        r_cidx <= r_idx;
        r_cv   <= 1'b1;
        if (r_idx != 4'd14) r_idx <= w_idx_p1;
      end
    end
  end

  assign bus.RD_Q       = r_rd_q;
  assign bus.wr_count   = r_wr_count;
  assign bus.check_done = (r_state == REPORT);
  assign bus.check_pass = (r_state == REPORT) && (r_err_code == 2'b00);
  assign bus.err_code   = r_err_code;
  assign bus.err_addr   = r_err_addr;

endmodule
